// File: rtl/count_sequencer.sv
// count_sequencer: programs an external loadable counter with a start value,
// lets it count up to a terminal value, and reports each completed period.
// Optional auto-reload repeats the period until an abort.
module count_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WIDTH-1:0]  cmd_end,
  input  logic              cmd_reload,
  input  logic              hold,
  input  logic              abort,
  output logic              ld,
  output logic              en,
  output logic [WIDTH-1:0]  input_value,
  input  logic [WIDTH-1:0]  counter,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount
  } state_e;

  localparam logic [PCNT_W-1:0] PcntOne = {{(PCNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   end_q, end_d;
  logic               reload_q, reload_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [PCNT_W-1:0]  period_cnt_q, period_cnt_d;

  logic at_end;

  // Terminal detection is independent of hold: a frozen counter already at
  // the end value still completes the period.
  assign at_end = (counter == end_q);

  // Next-state, command capture and completion/abort bookkeeping.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    reload_d     = reload_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    period_cnt_d = period_cnt_q;

    unique case (state_q)
      StIdle: begin
        // abort has no meaning here; only a command moves us on.
        if (cmd_valid) begin
          start_d      = cmd_start;
          end_d        = cmd_end;
          reload_d     = cmd_reload;
          period_cnt_d = '0;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StCount;
        end
      end
      StCount: begin
        // Abort wins over a coinciding terminal: no done, no count.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (at_end) begin
          done_d = 1'b1;
          if (period_cnt_q != '1) begin
            period_cnt_d = period_cnt_q + PcntOne;
          end
          state_d = reload_q ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter control is combinational so abort/hold take effect in the same cycle.
  always_comb begin
    cmd_ready   = (state_q == StIdle);
    busy        = (state_q != StIdle);
    ld          = (state_q == StLoad) && !abort;
    en          = (state_q == StCount) && !abort && !hold && !at_end;
    input_value = start_q;
    done        = done_q;
    aborted     = aborted_q;
    period_cnt  = period_cnt_q;
  end

  // State and captured command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      start_q      <= '0;
      end_q        <= '0;
      reload_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      end_q        <= end_d;
      reload_q     <= reload_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      period_cnt_q <= period_cnt_d;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: models the external 8-bit loadable counter and
// scoreboards every done pulse (cycle, period count, en cycles in the period).
module tb_count_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned P = 8;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_end;
  logic         cmd_reload;
  logic         hold;
  logic         abort;
  logic         ld;
  logic         en;
  logic [W-1:0] input_value;
  logic [W-1:0] counter;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [P-1:0] period_cnt;

  count_sequencer #(
    .WIDTH (W),
    .PCNT_W(P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .cmd_reload (cmd_reload),
    .hold       (hold),
    .abort      (abort),
    .ld         (ld),
    .en         (en),
    .input_value(input_value),
    .counter    (counter),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .period_cnt (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: ld over en, wraps modulo 2^W.
  always @(posedge clk or negedge rst) begin
    if (!rst)    counter <= '0;
    else if (ld) counter <= input_value;
    else if (en) counter <= counter + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int exp_cyc;
    int exp_pcnt;
    int exp_en;
  } exp_t;

  exp_t sb[$];
  int   en_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Done monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (ld)      en_cnt <= 0;
      else if (en) en_cnt <= en_cnt + 1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("done_cyc_%0d", e.id), cyc, e.exp_cyc);
          check($sformatf("pcnt_%0d", e.id), int'(period_cnt), e.exp_pcnt);
          check($sformatf("en_cycles_%0d", e.id), en_cnt, e.exp_en);
        end
      end
    end
  end

  // Offer a command at a negedge; it is accepted at the next edge, whose
  // cycle number is returned. Returns #1 after that edge (LOAD cycle).
  task automatic send(input int s, input int e, input bit r, output int acc);
    @(negedge clk);
    cmd_start  = W'(s);
    cmd_end    = W'(e);
    cmd_reload = r;
    cmd_valid  = 1'b1;
    acc        = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    // Scramble the command bus: it must not matter after accept.
    cmd_start  = 8'hAA;
    cmd_end    = 8'h55;
    cmd_reload = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1);
  end

  int e0;

  initial begin
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_start  = '0;
    cmd_end    = '0;
    cmd_reload = 1'b0;
    hold       = 1'b0;
    abort      = 1'b0;

    // Reset / idle
    #1;
    check("rst_ld", int'(ld), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_pcnt", int'(period_cnt), 0);
    check("rst_ival", int'(input_value), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_ld", int'(ld), 0);
    check("idle_en", int'(en), 0);

    // Basic run 1 -> 5: 4 steps, done after edge E+6
    send(1, 5, 1'b0, e0);
    sb.push_back('{1, e0 + 6, 1, 4});
    check("basic_ld", int'(ld), 1);
    check("basic_load_en", int'(en), 0);
    check("basic_busy", int'(busy), 1);
    check("basic_ready", int'(cmd_ready), 0);
    check("basic_ival", int'(input_value), 1);
    @(posedge clk);
    #1;
    check("basic_ld_low", int'(ld), 0);
    check("basic_en", int'(en), 1);
    check("basic_cnt_start", int'(counter), 1);
    wait_idle("basic");
    check("basic_cnt_end", int'(counter), 5);
    check("basic_ready_after", int'(cmd_ready), 1);
    check("basic_en_after", int'(en), 0);

    // Wrap 250 -> 2: 8 steps through 255 -> 0
    send(250, 2, 1'b0, e0);
    sb.push_back('{2, e0 + 10, 1, 8});
    wait_idle("wrap");
    check("wrap_cnt_end", int'(counter), 2);

    // start == end: no en cycles, done one edge after LOAD
    send(7, 7, 1'b0, e0);
    sb.push_back('{3, e0 + 2, 1, 0});
    wait_idle("equal");

    // Hold 3 cycles mid-count: 0 -> 3 delayed by exactly 3
    send(0, 3, 1'b0, e0);
    sb.push_back('{4, e0 + 5 + 3, 1, 3});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("hold_cnt_pre", int'(counter), 1);
    hold = 1'b1;
    #1;
    check("hold_en", int'(en), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_frozen", int'(counter), 1);
      check("hold_busy", int'(busy), 1);
    end
    hold = 1'b0;
    #1;
    check("hold_release_en", int'(en), 1);
    wait_idle("hold");

    // Reload 2 -> 4: done every 4 cycles, period_cnt counts up
    send(2, 4, 1'b1, e0);
    sb.push_back('{5, e0 + 4, 1, 2});
    sb.push_back('{6, e0 + 8, 2, 2});
    sb.push_back('{7, e0 + 12, 3, 2});
    wait_cyc(e0 + 12);
    check("reload_done3", int'(done), 1);
    check("reload_busy", int'(busy), 1);
    abort = 1'b1;
    #1;
    check("reload_abort_ld", int'(ld), 0);
    check("reload_abort_en", int'(en), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("reload_aborted", int'(aborted), 1);
    check("reload_idle", int'(busy), 0);
    check("reload_no_done", int'(done), 0);
    check("reload_pcnt_keep", int'(period_cnt), 3);
    @(posedge clk);
    #1;
    check("reload_aborted_pulse", int'(aborted), 0);
    repeat (8) @(negedge clk);

    // Abort at counter == 3 of 0 -> 9
    send(0, 9, 1'b0, e0);
    wait_cyc(e0 + 4);
    check("abort_cnt3", int'(counter), 3);
    check("abort_en_pre", int'(en), 1);
    abort = 1'b1;
    #1;
    check("abort_en", int'(en), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_pulse", int'(aborted), 1);
    check("abort_idle", int'(busy), 0);
    check("abort_cnt_frozen", int'(counter), 3);
    @(posedge clk);
    #1;
    check("abort_pulse_end", int'(aborted), 0);
    // Abort in idle is ignored
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle_ignored", int'(aborted), 0);
    repeat (12) @(negedge clk);

    // Async reset mid-COUNT
    send(5, 14, 1'b0, e0);
    wait_cyc(e0 + 4);
    check("rstmid_ival_pre", int'(input_value), 5);
    check("rstmid_busy_pre", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_ready", int'(cmd_ready), 1);
    check("rstmid_en", int'(en), 0);
    check("rstmid_ld", int'(ld), 0);
    check("rstmid_ival", int'(input_value), 0);
    check("rstmid_pcnt", int'(period_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_still_idle", int'(busy), 0);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences one external 8-bit loadable counter (ports ld/en/input_value/counter; ld has priority over en; +1 per enabled clk; wraps modulo 2^WIDTH). It accepts a command (start value, end value, reload flag) over a valid/ready handshake. It then drives ld for one cycle and en until the counter reaches the end value, and reports completion. Used as the programmable-interval engine in front of the counter datapath.

Parameters:
WIDTH, 8, width of counter, start and end values
PCNT_W, 8, width of completed-period counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept command
cmd_start  input  WIDTH  value loaded into counter
cmd_end  input  WIDTH  terminal value
cmd_reload  input  1  1 = auto-reload and repeat until abort
hold  input  1  pause counting (en forced low)
abort  input  1  cancel active command
ld  output  1  to counter ld
en  output  1  to counter en
input_value  output  WIDTH  to counter input_value
counter  input  WIDTH  current counter value (feedback)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on period completion
aborted  output  1  one-cycle pulse on abort
period_cnt  output  PCNT_W  completed periods since last accept, saturating

Behaviour:
- Reset (rst=0, any time, async): state IDLE, start_r/end_r/reload_r=0, done=0, aborted=0, period_cnt=0. ld=0, en=0, input_value=0, cmd_ready=1.
- States: IDLE, LOAD, COUNT.
- IDLE:
  - cmd_ready=1.
  - Accept on the edge where cmd_valid&cmd_ready: latch start/end/reload, clear period_cnt, go LOAD.
  - No accept in any other state (cmd_ready=0 there).
- LOAD:
  - ld=1, input_value=start_r, en=0, exactly one cycle.
  - Go COUNT.
- COUNT:
  - en = !hold && (counter != end_r), combinational.
  - ld=0; input_value holds start_r.
  - On an edge where counter==end_r: done=1 registered (high the following cycle), period_cnt+1 saturating at all-ones.
  - Then next state is LOAD if reload_r, else IDLE.
- hold: freezes en only. State and terminal detection are unaffected. Terminal is still detected while hold=1 (counter already equal).
- Wrap: counter steps modulo 2^WIDTH. Steps per period = (end_r - start_r) mod 2^WIDTH, no error for end<start.
- start==end: zero en cycles; done one edge after LOAD.
- abort (LOAD or COUNT):
  - Highest priority; ld=0, en=0 combinationally that cycle.
  - Next edge: IDLE, aborted=1 for one cycle, done not asserted even if terminal coincides.
  - abort in IDLE is ignored.
- Latency, non-reload:
  - Accept at edge E.
  - ld high in cycle E..E+1; counter=start after E+1.
  - done high in cycle after edge E+2+steps.
  - busy falls the same edge done rises.
- Reload: after done, the next cycle is LOAD (ld=1), so there is one dead cycle per period. busy stays 1.
- cmd_* are sampled only at accept; later changes have no effect.

Test Plan:
- Reset/idle: rst=0 then 1, no command -> ld=0, en=0, busy=0, cmd_ready=1, period_cnt=0.
- Basic run: start=1, end=5, reload=0, accepted at edge 0 -> ld=1 one cycle; en=1 for 4 cycles (counter 1..4); counter=5; done=1 one cycle after edge 6; busy=0, cmd_ready=1 thereafter.
- Wrap and equal: start=250, end=2 -> 8 en cycles through 255->0, done once. Then start=end=7 -> 0 en cycles, done one edge after LOAD.
- Hold: start=0, end=3, hold=1 for 3 cycles mid-count -> en low during hold, counter frozen, done delayed exactly 3 cycles vs. no-hold run.
- Reload: start=2, end=4, reload=1, run 3 periods -> done pulse every 4 cycles (LOAD + 2 counts + terminal), period_cnt=1,2,3; abort -> aborted pulse, IDLE, no further done.
- Abort/reset mid-op: abort while counter=3 of 0->9 -> en=0 same cycle, aborted=1 next, done never. rst low mid-COUNT -> all outputs to reset values immediately, without waiting for a clock.
